// File: rtl/icu_vectored.sv
// icu_vectored: vectored interrupt control unit.
// Samples NUM_SRC masked level requests, picks one, stalls the pipeline for
// STALL_CYCLES, pushes CCR/PCL/PCH, then branches to the source's vector and
// pulses a one-hot acknowledge. A served source re-arms only after its
// sampled request has been low for at least one cycle.
// Optional feature macro: ICU_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed lowest-index priority.
module icu_vectored #(
  parameter int NUM_SRC      = 4,
  parameter int PC_W         = 32,
  parameter int VEC_BASE     = 0,
  parameter int VEC_STRIDE   = 2,
  parameter int STALL_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] irq_mask,
  output logic               stall,
  output logic               stack_op,
  output logic               push_pop,
  output logic [3:0]         reg_id,
  output logic               branch,
  output logic [PC_W-1:0]    pc_value,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic               busy
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    STALL,
    PUSH_CCR,
    PUSH_PCL,
    PUSH_PCH,
    BRANCH
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] irq_q_reg;
  logic [NUM_SRC-1:0] served_reg, served_next;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ack_onehot;
  logic [IW-1:0]      sel_id_reg;
  logic [IW-1:0]      win_id;
  logic               win_found;
  logic [CW-1:0]      cnt_reg;
  logic               stall_done;
  logic [PC_W-1:0]    vec_addr;

  assign eligible   = irq_q_reg & ~served_reg;
  assign stall_done = (cnt_reg == CW'(STALL_CYCLES - 1));
  assign vec_addr   = PC_W'(VEC_BASE) + PC_W'(sel_id_reg) * PC_W'(VEC_STRIDE);

  // Per-source served flag: set by our own ack, dropped once the sampled
  // request is seen low; also the one-hot decode of the latched winner.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign ack_onehot[gi]  = (sel_id_reg == IW'(gi));
      assign served_next[gi] = ((state_reg == BRANCH) && ack_onehot[gi]) ? 1'b1
                             : (served_reg[gi] & irq_q_reg[gi]);
    end
  endgenerate

`ifdef ICU_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_reg;

  // Round-robin search: first eligible index at or after the pointer, wrapping.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!win_found && eligible[IW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  // Pointer moves to the index after the source just acknowledged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (enable && (state_reg == BRANCH)) begin
      if (sel_id_reg == IW'(NUM_SRC - 1)) ptr_reg <= '0;
      else                                ptr_reg <= sel_id_reg + 1'b1;
    end
  end
`else
  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && eligible[i]) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
  end
`endif

  // Request sampling, served tracking, stall counter and winner latch;
  // disabling the block wipes them exactly like reset.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      irq_q_reg  <= '0;
      served_reg <= '0;
      cnt_reg    <= '0;
      sel_id_reg <= '0;
    end else begin
      irq_q_reg  <= irq & ~irq_mask;
      served_reg <= served_next;
      if ((state_reg == STALL) && !stall_done) cnt_reg <= cnt_reg + 1'b1;
      else                                      cnt_reg <= '0;
      if ((state_reg == IDLE) && win_found) sel_id_reg <= win_id;
    end
  end

  // State register; reset and disable both abort any sequence in flight.
  always_ff @(posedge clk) begin
    if (!reset || !enable) state_reg <= IDLE;
    else                   state_reg <= state_next;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    stack_op   = 1'b0;
    push_pop   = 1'b0;
    reg_id     = 4'd0;
    branch     = 1'b0;
    pc_value   = '0;
    irq_ack    = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (win_found) state_next = STALL;
      end
      STALL: begin
        stall = 1'b1;
        if (stall_done) state_next = PUSH_CCR;
      end
      PUSH_CCR: begin
        stack_op   = 1'b1;
        push_pop   = 1'b1;
        reg_id     = 4'd10;
        state_next = PUSH_PCL;
      end
      PUSH_PCL: begin
        stack_op   = 1'b1;
        push_pop   = 1'b1;
        reg_id     = 4'd8;
        state_next = PUSH_PCH;
      end
      PUSH_PCH: begin
        stack_op   = 1'b1;
        push_pop   = 1'b1;
        reg_id     = 4'd9;
        state_next = BRANCH;
      end
      BRANCH: begin
        branch     = 1'b1;
        pc_value   = vec_addr;
        irq_ack    = ack_onehot;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icu_vectored.sv
// tb_icu_vectored: directed self-checking bench for icu_vectored in its
// default configuration (4 sources, stride 2, one stall cycle, fixed priority).
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_icu_vectored;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  irq;
  logic [3:0]  irq_mask;
  logic        stall;
  logic        stack_op;
  logic        push_pop;
  logic [3:0]  reg_id;
  logic        branch;
  logic [31:0] pc_value;
  logic [3:0]  irq_ack;
  logic        busy;

  int total;
  int bad;

  icu_vectored dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .irq      (irq),
    .irq_mask (irq_mask),
    .stall    (stall),
    .stack_op (stack_op),
    .push_pop (push_pop),
    .reg_id   (reg_id),
    .branch   (branch),
    .pc_value (pc_value),
    .irq_ack  (irq_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, stall, stack_op, push_pop, reg_id, branch, pc_value, irq_ack}
  logic [44:0] obs;
  assign obs = {busy, stall, stack_op, push_pop, reg_id, branch, pc_value, irq_ack};

  // Expected outputs for a step of a sequence: 0 idle, 1 stall,
  // 2/3/4 pushes CCR/PCL/PCH, 5 branch with vector and ack.
  function automatic logic [44:0] exp_vec(input int step, input logic [31:0] pc,
                                          input logic [3:0] ack);
    case (step)
      1:       return {1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 32'd0, 4'd0};
      2:       return {1'b1, 1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 32'd0, 4'd0};
      3:       return {1'b1, 1'b0, 1'b1, 1'b1, 4'd8,  1'b0, 32'd0, 4'd0};
      4:       return {1'b1, 1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 32'd0, 4'd0};
      5:       return {1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, pc,    ack};
      default: return 45'd0;
    endcase
  endfunction

  // Falling edge k after a request is raised maps to sequence step:
  // k=1 still idle (request being sampled), k=2..6 steps 1..5, then idle.
  function automatic int seq_step(input int k);
    if (k >= 2 && k <= 6) return k - 1;
    return 0;
  endfunction

  task automatic test_reset();
    logic [44:0] exp;
    reset    = 1'b0;
    enable   = 1'b1;
    irq      = 4'b1111;
    irq_mask = 4'b0000;
    exp      = 45'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_hold k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq   = 4'b0000;
    reset = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_release k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    $display("reset: outputs idle during and after reset");
  endtask

  task automatic test_single();
    logic [44:0] exp;
    irq = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = exp_vec(seq_step(k), 32'd4, 4'b0100);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    $display("single: src2 pc=4 ack=0100");
  endtask

  task automatic test_hold_after_ack();
    logic [44:0] exp;
    exp = 45'd0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL hold_no_reservice k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq = 4'b0000;
    @(negedge clk);
    irq = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = exp_vec(seq_step(k), 32'd4, 4'b0100);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL hold_rearm k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq = 4'b0000;
    repeat (3) @(negedge clk);
    $display("hold: src2 re-serviced only after dropping irq");
  endtask

  task automatic test_back_to_back();
    logic [44:0] exp;
    irq = 4'b1010;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k <= 6)       exp = exp_vec(seq_step(k), 32'd2, 4'b0010);
      else if (k == 7)  exp = 45'd0;
      else              exp = exp_vec(seq_step(k - 6), 32'd6, 4'b1000);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL back_to_back k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq = 4'b0000;
    repeat (3) @(negedge clk);
    $display("back_to_back: src1 pc=2 then src3 pc=6");
  endtask

  task automatic test_mask();
    logic [44:0] exp;
    irq      = 4'b0001;
    irq_mask = 4'b0001;
    exp      = 45'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL mask_hold k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq_mask = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = exp_vec(seq_step(k), 32'd0, 4'b0001);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL mask_clear k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq = 4'b0000;
    repeat (3) @(negedge clk);
    $display("mask: src0 held off, then pc=0 ack=0001");
  endtask

  task automatic test_abort_reset();
    logic [44:0] exp;
    irq = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp = exp_vec(seq_step(k), 32'd0, 4'b0001);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL abort_pre k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    exp = 45'd0;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL abort_cleared got=%h want=%h", obs, exp);
    end
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = exp_vec(seq_step(k), 32'd0, 4'b0001);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL abort_reservice k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq = 4'b0000;
    repeat (3) @(negedge clk);
    $display("abort_reset: src0 aborted in PUSH_PCL, then serviced fully");
  endtask

  task automatic test_abort_enable();
    logic [44:0] exp;
    irq = 4'b0010;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      exp = exp_vec(seq_step(k), 32'd2, 4'b0010);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL disable_pre k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    enable = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      exp = 45'd0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL disable_idle k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = exp_vec(seq_step(k), 32'd2, 4'b0010);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL disable_reservice k=%0d got=%h want=%h", k, obs, exp);
      end
    end
    irq = 4'b0000;
    repeat (3) @(negedge clk);
    $display("abort_enable: src1 aborted in STALL, then pc=2 ack=0010");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_hold_after_ack();
    test_back_to_back();
    test_mask();
    test_abort_reset();
    test_abort_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
